// File: rtl/spi_pkg.sv
// Shared SPI slave constants: mode encodings, default word width, FSM states.
package spi_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  localparam int unsigned CPOL_LOW   = 0;
  localparam int unsigned CPOL_HIGH  = 1;
  localparam int unsigned CPHA_LEAD  = 0;
  localparam int unsigned CPHA_TRAIL = 1;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus delay flop; gives synced level and edge strobes.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic s1;
  logic s2;
  logic dly;

  // Resynchronise the pin and keep one older sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= RST_VAL;
      s2  <= RST_VAL;
      dly <= RST_VAL;
    end else begin
      s1  <= din;
      s2  <= s1;
      dly <= s2;
    end
  end

  assign level  = s2;
  assign rise_c = s2 & ~dly;
  assign fall_c = ~s2 & dly;

endmodule

// File: rtl/spi_slave_sync.sv
// Oversampled SPI target: shifts DATA_W-bit words in/out in any CPOL/CPHA mode.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CPOL   = CPOL_LOW,
  parameter int unsigned CPHA   = CPHA_LEAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_empty,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int unsigned CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic        CPOL_BIT = 1'(CPOL);

  spi_state_e        state;
  logic [1:0]        settle_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic              word_done;
  logic              mosi_s1;
  logic              mosi_s2;

  logic              sclk_level;
  logic              sclk_rise_c;
  logic              sclk_fall_c;
  logic              cs_level;
  logic              cs_rise_c;
  logic              cs_fall_c;
  logic              sclk_edge_c;
  logic              lead_c;
  logic              trail_c;
  logic              sample_c;
  logic              shift_c;
  logic              word_end_c;
  logic              load_c;
  logic [DATA_W-1:0] load_word_c;

  spi_sync_edge #(.RST_VAL(CPOL_BIT)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (sclk),
    .level  (sclk_level),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (cs_n),
    .level  (cs_level),
    .rise_c (cs_rise_c),
    .fall_c (cs_fall_c)
  );

  // Plain two-flop path for mosi; same latency as the sclk edge strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // Classify sclk edges by direction relative to the idle level
  assign sclk_edge_c = sclk_rise_c | sclk_fall_c;
  assign lead_c      = sclk_edge_c & (sclk_level != CPOL_BIT);
  assign trail_c     = sclk_edge_c & (sclk_level == CPOL_BIT);
  assign sample_c    = (CPHA != 0) ? trail_c : lead_c;
  assign shift_c     = (CPHA != 0) ? lead_c : trail_c;
  assign word_end_c  = sample_c && (bit_cnt == CNT_W'(DATA_W - 1));
  assign load_c      = ((state == ST_IDLE) && cs_fall_c) ||
                       ((state == ST_ACTIVE) && !cs_rise_c && word_end_c);

  // A tx_load coinciding with a word load bypasses the hold register
  always_comb begin
    load_word_c = hold;
    if (tx_load) load_word_c = tx_data;
  end

  // Frame FSM, shift registers and tx hold-register bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_WAIT_IDLE;
      settle_cnt  <= '0;
      bit_cnt     <= '0;
      hold        <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      word_done   <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      tx_empty    <= 1'b1;
      tx_underrun <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      word_done   <= 1'b0;

      if (load_c) begin
        tx_empty    <= 1'b1;
        tx_underrun <= tx_empty & ~tx_load;
      end else if (tx_load) begin
        hold     <= tx_data;
        tx_empty <= 1'b0;
      end

      if (word_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end

      case (state)
        ST_WAIT_IDLE: begin
          // Let real pin values reach the synchroniser output before trusting cs_n
          if (settle_cnt != 2'd2) begin
            settle_cnt <= settle_cnt + 2'd1;
          end else if (cs_level) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (cs_fall_c) begin
            state    <= ST_ACTIVE;
            busy     <= 1'b1;
            miso_oe  <= 1'b1;
            bit_cnt  <= '0;
            rx_shift <= '0;
            if (CPHA == 0) begin
              miso     <= load_word_c[DATA_W-1];
              tx_shift <= {load_word_c[DATA_W-2:0], 1'b0};
            end else begin
              tx_shift <= load_word_c;
            end
          end
        end
        ST_ACTIVE: begin
          if (cs_rise_c) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            miso_oe  <= 1'b0;
            miso     <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end else begin
            if (shift_c) begin
              miso     <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (sample_c) begin
              rx_shift <= {rx_shift[DATA_W-2:0], mosi_s2};
              if (word_end_c) begin
                bit_cnt   <= '0;
                word_done <= 1'b1;
                tx_shift  <= load_word_c;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

endmodule
